efc_transition_driver: RTL
==========================

# efc_transition_driver

Upstream command stage for the synchronous Mealy FSM decomposition of the simple EFC net (FSM1, FSM2, FSM3). It accepts one transition-firing command at a time over a valid/ready interface. It checks the transition against the place outputs the three FSMs export, and drives a one-cycle strobe on the matching `tK_` input. It then watches the place outputs for confirmation and returns a status code, keeping a count of confirmed firings.

## Interface
- `TIMEOUT_CYCLES`, 15: wait cycles allowed for confirmation after the strobe; legal range 1..255.
- `CNT_W`, 16: width of `fire_count`.

- `clk`  in  1  rising-edge clock shared with the three FSMs.
- `reset`  in  1  asynchronous, active-low reset; one clock only.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_trans`  in  3  transition index, 0..6 = t0..t6; 7 is illegal.
- `t_strobe`  out  7  bit k drives `tk_` of every FSM that has tk.
- `place_obs`  in  10  FSM place outputs: [0] p0/FSM1, [1] p2/FSM1, [2] p4/FSM1, [3] p6/FSM1, [4] p7/FSM2, [5] p0/FSM2, [6] p1/FSM3, [7] p2/FSM3, [8] p4/FSM3, [9] p6/FSM3.
- `rsp_valid`  out  1  one-cycle response pulse; there is no backpressure.
- `rsp_code`  out  2  0 OK, 1 NOT_ENABLED, 2 TIMEOUT, 3 BAD_INDEX; valid only with `rsp_valid`.
- `fire_count`  out  CNT_W  confirmed firings since reset.

## Operation
- FSM states: IDLE, STROBE, WAIT, RESP. All outputs are registered.
- Enable condition, evaluated on `place_obs` in the accept cycle:
  - t0, t1: p0/FSM1 & p0/FSM2 & p1/FSM3.
  - t2: p2/FSM1 & p2/FSM3.
  - t4: p4/FSM1 & p4/FSM3.
  - t3, t5: ~p7/FSM2 & ~p0/FSM2, meaning FSM2 is in p3 or p5. The block cannot tell p3 from p5.
  - t6: p6/FSM1 & p6/FSM3 & p7/FSM2.
- Confirm condition, evaluated each WAIT cycle:
  - t0: p2/FSM1 & p2/FSM3 & ~p0/FSM2.
  - t1: p4/FSM1 & p4/FSM3 & ~p0/FSM2.
  - t2, t4: p6/FSM1 & p6/FSM3.
  - t3, t5: p7/FSM2.
  - t6: p0/FSM1 & p0/FSM2 & p1/FSM3.
- IDLE:
  - `cmd_ready`=1; a handshake (`cmd_valid` & `cmd_ready`) latches `cmd_trans`.
  - Index 7 goes to RESP with code BAD_INDEX.
  - A disabled transition goes to RESP with code NOT_ENABLED.
  - Otherwise go to STROBE.
- STROBE: exactly one bit of `t_strobe` is high, for exactly one cycle. Then go to WAIT with the timeout counter at 0.
- WAIT:
  - Confirm seen: go to RESP with OK and increment `fire_count`, which wraps from all-ones to 0.
  - Else, counter == TIMEOUT_CYCLES-1: go to RESP with TIMEOUT.
  - Else the counter increments.
  - Confirm wins over timeout in the same cycle.
- RESP: `rsp_valid`=1 for one cycle, then return to IDLE.
- Only one command is in flight. `cmd_ready` is 0 from the accept edge until the cycle after RESP.
- `t_strobe` is never multi-hot. A timed-out t3/t5 leaves the FSMs unchanged.

## Timing
- Reset values: `cmd_ready`=0, `t_strobe`=0, `rsp_valid`=0, `rsp_code`=0, `fire_count`=0, state IDLE, counter 0.
- `cmd_ready` rises in the first cycle after `reset` deasserts.
- Let N be the accept cycle:
  - Strobe is in cycle N+1, so the FSMs sample it at the end of N+1.
  - The earliest confirm is in N+2; OK response in N+3; `cmd_ready` is high again in N+4.
  - NOT_ENABLED or BAD_INDEX: response in N+1, no strobe; `cmd_ready` high in N+2.
  - TIMEOUT: WAIT occupies N+2..N+1+TIMEOUT_CYCLES; response in N+2+TIMEOUT_CYCLES.
- Reset asserted mid-operation forces every output and register to its reset value immediately. Any strobe in progress is cut, and no response is issued for the aborted command.

## Structure
- Package `efc_pkg` holds:
  - transition index constants T0..T6 and T_ILLEGAL=7;
  - the `rsp_code` enum (RSP_OK, RSP_NOT_ENABLED, RSP_TIMEOUT, RSP_BAD_INDEX);
  - the state enum;
  - `place_obs` bit-position constants.
- Sub-module `efc_marking_decode` is purely combinational: `place_obs` to 7-bit `enabled` and 7-bit `confirmed` vectors. The driver indexes both with the latched transition.

## Test plan
- Reset then `cmd_trans`=0 against behavioural FSM1-3 → `t_strobe`=7'b0000001 in N+1 only; `rsp_code`=OK in N+3; `fire_count`=1.
- Initial marking, `cmd_trans`=2 → `rsp_valid` in N+1 with code 1; `t_strobe` stays 0; `fire_count` unchanged.
- `cmd_trans`=7 → code 3 in N+1; a second command is accepted in N+2.
- t1 then t3 (FSM2 in p5) → t3 strobe, no confirm; TIMEOUT in N+17 with TIMEOUT_CYCLES=15; marking unchanged; t5 then confirms OK.
- Sequence t0, t2, t3, t6, with `cmd_valid` held continuously → four OK responses, each 4 cycles apart; `fire_count`=4; `place_obs` returns to the initial pattern.
- `reset` pulled low during WAIT → all outputs zero within the same cycle; after release, `cmd_ready`=1 one cycle later and `fire_count`=0.

Source files
------------

// File: rtl/efc_pkg.sv
// Shared constants and types for the EFC transition driver: transition indices,
// place_obs bit positions, response codes and driver states.
package efc_pkg;

    localparam int NUM_TRANS = 7;
    localparam int PLACE_W   = 10;

    localparam logic [2:0] T0        = 3'd0;
    localparam logic [2:0] T1        = 3'd1;
    localparam logic [2:0] T2        = 3'd2;
    localparam logic [2:0] T3        = 3'd3;
    localparam logic [2:0] T4        = 3'd4;
    localparam logic [2:0] T5        = 3'd5;
    localparam logic [2:0] T6        = 3'd6;
    localparam logic [2:0] T_ILLEGAL = 3'd7;

    // Bit positions of the place outputs exported by FSM1..FSM3
    localparam int P_F1_P0 = 0;
    localparam int P_F1_P2 = 1;
    localparam int P_F1_P4 = 2;
    localparam int P_F1_P6 = 3;
    localparam int P_F2_P7 = 4;
    localparam int P_F2_P0 = 5;
    localparam int P_F3_P1 = 6;
    localparam int P_F3_P2 = 7;
    localparam int P_F3_P4 = 8;
    localparam int P_F3_P6 = 9;

    typedef enum logic [1:0] {
        RSP_OK          = 2'd0,
        RSP_NOT_ENABLED = 2'd1,
        RSP_TIMEOUT     = 2'd2,
        RSP_BAD_INDEX   = 2'd3
    } rsp_code_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } drv_state_t;

    // One-hot strobe for a transition index; the illegal index maps to all-zero.
    function automatic logic [NUM_TRANS-1:0] trans_onehot(input logic [2:0] idx);
        logic [7:0] wide;
        wide = 8'd1 << idx;
        return wide[NUM_TRANS-1:0];
    endfunction

endpackage

// File: rtl/efc_marking_decode.sv
// Combinational decode of the observable marking into per-transition
// enabled and confirmed flags.
module efc_marking_decode
    import efc_pkg::*;
(
    input  logic [PLACE_W-1:0]   place_obs,
    output logic [NUM_TRANS-1:0] enabled,
    output logic [NUM_TRANS-1:0] confirmed
);

    logic f1_p0, f1_p2, f1_p4, f1_p6;
    logic f2_p7, f2_p0;
    logic f3_p1, f3_p2, f3_p4, f3_p6;
    logic initial_marking;

    assign f1_p0 = place_obs[P_F1_P0];
    assign f1_p2 = place_obs[P_F1_P2];
    assign f1_p4 = place_obs[P_F1_P4];
    assign f1_p6 = place_obs[P_F1_P6];
    assign f2_p7 = place_obs[P_F2_P7];
    assign f2_p0 = place_obs[P_F2_P0];
    assign f3_p1 = place_obs[P_F3_P1];
    assign f3_p2 = place_obs[P_F3_P2];
    assign f3_p4 = place_obs[P_F3_P4];
    assign f3_p6 = place_obs[P_F3_P6];

    assign initial_marking = f1_p0 & f2_p0 & f3_p1;

    // FSM2 in neither p7 nor p0 means p3 or p5; the two are indistinguishable here.
    assign enabled[T0] = initial_marking;
    assign enabled[T1] = initial_marking;
    assign enabled[T2] = f1_p2 & f3_p2;
    assign enabled[T3] = ~f2_p7 & ~f2_p0;
    assign enabled[T4] = f1_p4 & f3_p4;
    assign enabled[T5] = ~f2_p7 & ~f2_p0;
    assign enabled[T6] = f1_p6 & f3_p6 & f2_p7;

    assign confirmed[T0] = f1_p2 & f3_p2 & ~f2_p0;
    assign confirmed[T1] = f1_p4 & f3_p4 & ~f2_p0;
    assign confirmed[T2] = f1_p6 & f3_p6;
    assign confirmed[T3] = f2_p7;
    assign confirmed[T4] = f1_p6 & f3_p6;
    assign confirmed[T5] = f2_p7;
    assign confirmed[T6] = initial_marking;

endmodule

// File: rtl/efc_transition_driver.sv
// Command stage for the FSM1/FSM2/FSM3 decomposition: checks a transition,
// strobes it for one cycle, waits for the marking to confirm and reports.
module efc_transition_driver
    import efc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_trans,
    output logic [NUM_TRANS-1:0] t_strobe,
    input  logic [PLACE_W-1:0]   place_obs,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_code,
    output logic [CNT_W-1:0]     fire_count
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    drv_state_t           state_reg;
    logic [2:0]           trans_reg;
    logic [7:0]           wait_cnt_reg;
    logic                 cmd_ready_reg;
    logic [NUM_TRANS-1:0] t_strobe_reg;
    logic                 rsp_valid_reg;
    rsp_code_t            rsp_code_reg;
    logic [CNT_W-1:0]     fire_count_reg;

    logic [NUM_TRANS-1:0] enabled;
    logic [NUM_TRANS-1:0] confirmed;
    logic [7:0]           enabled_ext;
    logic [7:0]           confirmed_ext;
    logic                 accept;

    efc_marking_decode u_decode (
        .place_obs (place_obs),
        .enabled   (enabled),
        .confirmed (confirmed)
    );

    // Padding bit 7 lets the 3-bit index address the vectors without range checks.
    assign enabled_ext   = {1'b0, enabled};
    assign confirmed_ext = {1'b0, confirmed};
    assign accept        = cmd_valid & cmd_ready_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            trans_reg      <= '0;
            wait_cnt_reg   <= '0;
            cmd_ready_reg  <= 1'b0;
            t_strobe_reg   <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_code_reg   <= RSP_OK;
            fire_count_reg <= '0;
        end else begin
            t_strobe_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        trans_reg     <= cmd_trans;
                        cmd_ready_reg <= 1'b0;
                        if (cmd_trans == T_ILLEGAL) begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_code_reg  <= RSP_BAD_INDEX;
                        end else if (!enabled_ext[cmd_trans]) begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_code_reg  <= RSP_NOT_ENABLED;
                        end else begin
                            state_reg    <= ST_STROBE;
                            t_strobe_reg <= trans_onehot(cmd_trans);
                        end
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                ST_STROBE: begin
                    state_reg    <= ST_WAIT;
                    wait_cnt_reg <= '0;
                end
                ST_WAIT: begin
                    // Confirmation takes priority over an expiring timeout.
                    if (confirmed_ext[trans_reg]) begin
                        state_reg      <= ST_RESP;
                        rsp_valid_reg  <= 1'b1;
                        rsp_code_reg   <= RSP_OK;
                        fire_count_reg <= fire_count_reg + CNT_W'(1);
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_code_reg  <= RSP_TIMEOUT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign t_strobe   = t_strobe_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_code   = rsp_code_reg;
    assign fire_count = fire_count_reg;

endmodule
